// File: rtl/alu_cmd_issue_if.sv
// Command/result bus between the ALU issue stage and its environment:
// upstream command handshake, operands to the external ALU, result handshake.
interface alu_cmd_issue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_a;
  logic [7:0]    in_b;
  logic [2:0]    in_sel;

  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [2:0]    alu_sel;
  logic [7:0]    alu_result;
  logic          alu_zero;

  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_result;
  logic          out_zero;

  logic [CW-1:0] fifo_count;

  // Issue-stage view
  modport slave (
    input  in_valid, in_a, in_b, in_sel,
    input  alu_result, alu_zero,
    input  out_ready,
    output in_ready,
    output alu_a, alu_b, alu_sel,
    output out_valid, out_result, out_zero,
    output fifo_count
  );

  // Environment view (command source, ALU, result sink)
  modport master (
    output in_valid, in_a, in_b, in_sel,
    output alu_result, alu_zero,
    output out_ready,
    input  in_ready,
    input  alu_a, alu_b, alu_sel,
    input  out_valid, out_result, out_zero,
    input  fifo_count
  );
endinterface

// File: rtl/alu_cmd_issue.sv
// Sequential issue stage around the 8-bit combinational ALU: command FIFO,
// operand issue register and result register. ALU_CMD_ISSUE_STATS_EN adds handshake counters.
module alu_cmd_issue #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input logic            clk,
  input logic            rst_n,
  input logic            flush,
  alu_cmd_issue_if.slave bus
`ifdef ALU_CMD_ISSUE_STATS_EN
  ,
  output logic [15:0]    op_count,
  output logic [15:0]    zero_count
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
  } cmd_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          iss_valid;
  logic [7:0]    alu_a_q;
  logic [7:0]    alu_b_q;
  logic [2:0]    alu_sel_q;

  logic          out_valid_q;
  logic [7:0]    out_result_q;
  logic          out_zero_q;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          adv;
  logic          out_hs;
  cmd_t          head;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == CW'(0));
  assign push   = bus.in_valid && !full;
  assign adv    = iss_valid && (!out_valid_q || bus.out_ready);
  // Empty FIFO cannot pop, so a push into it only becomes visible next cycle
  assign pop    = !empty && (!iss_valid || adv);
  assign out_hs = out_valid_q && bus.out_ready;
  assign head   = mem[rd_ptr];

  assign bus.in_ready   = !full;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_zero   = out_zero_q;
  assign bus.fifo_count = count;

  // Command storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b, sel: bus.in_sel};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  // Issue register; operands hold their last value while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
    end else if (flush) begin
      iss_valid <= 1'b0;
    end else if (pop) begin
      iss_valid <= 1'b1;
      alu_a_q   <= head.a;
      alu_b_q   <= head.b;
      alu_sel_q <= head.sel;
    end else if (adv) begin
      iss_valid <= 1'b0;
    end
  end

  // Result register with downstream backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
    end else if (adv) begin
      out_valid_q  <= 1'b1;
      out_result_q <= bus.alu_result;
      out_zero_q   <= bus.alu_zero;
    end else if (out_hs) begin
      out_valid_q  <= 1'b0;
    end
  end

`ifdef ALU_CMD_ISSUE_STATS_EN
  // Saturating counts of accepted results and of those flagged zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count   <= '0;
      zero_count <= '0;
    end else if (flush) begin
      op_count   <= '0;
      zero_count <= '0;
    end else if (out_hs) begin
      if (op_count != 16'hFFFF) begin
        op_count <= op_count + 16'd1;
      end
      if (out_zero_q && (zero_count != 16'hFFFF)) begin
        zero_count <= zero_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Scoreboard bench for alu_cmd_issue with a behavioural ALU closing the loop.
module tb_alu_cmd_issue;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;
  logic flush;
`ifdef ALU_CMD_ISSUE_STATS_EN
  logic [15:0] op_count;
  logic [15:0] zero_count;
`endif

  alu_cmd_issue_if #(.DEPTH(DEPTH)) bus ();

  alu_cmd_issue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
`ifdef ALU_CMD_ISSUE_STATS_EN
    ,
    .op_count   (op_count),
    .zero_count (zero_count)
`endif
  );

  typedef struct packed {
    logic [7:0] res;
    logic       z;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned hs_cyc[$];
  int unsigned cyc;
  int unsigned last_acc;
  int unsigned n_cmp;
  int unsigned n_err;
  logic [7:0]  alu_r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: 000 ADD, 001 SUB, 010 MUL, 011 OR, 100 XOR, 101 AND, 110 NOT, 111 NOP
  always_comb begin
    alu_r = 8'h00;
    case (bus.alu_sel)
      3'b000:  alu_r = bus.alu_a + bus.alu_b;
      3'b001:  alu_r = bus.alu_a - bus.alu_b;
      3'b010:  alu_r = 8'(16'(bus.alu_a) * 16'(bus.alu_b));
      3'b011:  alu_r = bus.alu_a | bus.alu_b;
      3'b100:  alu_r = bus.alu_a ^ bus.alu_b;
      3'b101:  alu_r = bus.alu_a & bus.alu_b;
      3'b110:  alu_r = ~bus.alu_a;
      default: alu_r = 8'h00;
    endcase
  end
  assign bus.alu_result = alu_r;
  assign bus.alu_zero   = (alu_r == 8'h00);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Result monitor: every handshake must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      exp_t e;
      int unsigned qs;
      qs = exp_q.size();
      check("sb_has_entry", (qs > 0) ? 32'd1 : 32'd0, 32'd1);
      if (qs > 0) begin
        e = exp_q.pop_front();
        check("out_result", 32'(bus.out_result), 32'(e.res));
        check("out_zero", 32'(bus.out_zero), 32'(e.z));
      end
      hs_cyc.push_back(cyc);
    end
  end

  // Drive one command starting at posedge+1; returns at posedge+1 after acceptance
  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                          input logic [7:0] er, input logic ez);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sel   = sel;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("push_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      @(posedge clk);
      exp_q.push_back('{res: er, z: ez});
    end
    #1;
    last_acc     = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_consec(input string tag, input int unsigned n);
    check(tag, 32'(hs_cyc.size()), 32'(n));
    for (int i = 1; i < hs_cyc.size(); i++) begin
      check(tag, hs_cyc[i] - hs_cyc[i-1], 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned first_acc;
    n_cmp         = 0;
    n_err         = 0;
    cyc           = 0;
    rst_n         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    bus.in_sel    = 3'b000;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    check("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
    check("rst_out_result", 32'(bus.out_result), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD with latency check
    bus.out_ready = 1'b1;
    hs_cyc.delete();
    push_cmd(8'h0F, 8'h01, 3'b000, 8'h10, 1'b0);
    first_acc = last_acc;
    wait_drain("add_drain");
    check("add_hs_count", 32'(hs_cyc.size()), 32'd1);
    if (hs_cyc.size() > 0) check("add_latency", hs_cyc[0] - first_acc, 32'd2);
    check("add_result_hold", 32'(bus.out_result), 32'h10);

    // SUB to zero, MUL truncating to zero
    push_cmd(8'h05, 8'h05, 3'b001, 8'h00, 1'b1);
    push_cmd(8'h10, 8'h10, 3'b010, 8'h00, 1'b1);
    wait_drain("submul_drain");

    // Full backpressure: DEPTH + 2 commands fit
    bus.out_ready = 1'b0;
    hs_cyc.delete();
    for (int i = 1; i <= 6; i++) push_cmd(8'(i), 8'h00, 3'b011, 8'(i), 1'b0);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_count", 32'(bus.fifo_count), 32'd4);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    check("bp_hold_count", 32'(bus.fifo_count), 32'd4);
    check("bp_no_hs", 32'(hs_cyc.size()), 32'd0);
    bus.out_ready = 1'b1;
    wait_drain("bp_drain");
    check_consec("bp_consec", 6);

    // Streaming XOR, one per cycle
    hs_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      push_cmd(8'(i), 8'hFF, 3'b100, ~8'(i), 1'b0);
      if (i == 0) first_acc = last_acc;
    end
    wait_drain("stream_drain");
    check_consec("stream_consec", 16);
    if (hs_cyc.size() > 0) check("stream_latency", hs_cyc[0] - first_acc, 32'd2);

    // Flush with 3 queued, 1 issued, 1 in result register and a concurrent push
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_cmd(8'h20 + 8'(i), 8'h01, 3'b000, 8'h21 + 8'(i), 1'b0);
    check("pre_flush_count", 32'(bus.fifo_count), 32'd3);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'h99;
    bus.in_b     = 8'h01;
    bus.in_sel   = 3'b000;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_count", 32'(bus.fifo_count), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_result_hold", 32'(bus.out_result), 32'h22);
    check("flush_alu_hold", 32'(bus.alu_a), 32'h22);
    exp_q.delete();
    hs_cyc.delete();
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("flush_no_result", 32'(hs_cyc.size()), 32'd0);
    push_cmd(8'h40, 8'h01, 3'b000, 8'h41, 1'b0);
    wait_drain("post_flush_drain");

    // Asynchronous reset mid-stream with 2 queued
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_cmd(8'h09, 8'(i), 3'b001, 8'h09 - 8'(i), 1'b0);
    check("pre_rst_count", 32'(bus.fifo_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_count", 32'(bus.fifo_count), 32'd0);
    check("mid_rst_alu_sel", 32'(bus.alu_sel), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    hs_cyc.delete();
    push_cmd(8'h02, 8'h03, 3'b000, 8'h05, 1'b0);
    wait_drain("post_rst_drain");
    check("post_rst_hs", 32'(hs_cyc.size()), 32'd1);
    check("post_rst_result", 32'(bus.out_result), 32'h05);

    repeat (3) @(posedge clk);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
